// File: rtl/conv_8bto32b_if.sv
// Byte-link receive bus for the 8-to-32 deserializer: the byte stream in, the restored word out.
interface conv_8bto32b_if;
   logic [7:0]  data_in;
   logic        valid_in;
   logic        sop_in;
   logic [31:0] data_out;
   logic        valid_out;
   logic        err_out;

   modport master (output data_in, valid_in, sop_in,
                   input  data_out, valid_out, err_out);
   modport slave  (input  data_in, valid_in, sop_in,
                   output data_out, valid_out, err_out);
endinterface

// File: rtl/conv_8bto32b.sv
// Byte-to-word deserializer: packs four accepted bytes into one 32-bit word with a one-cycle valid pulse.
//
// state | meaning
// B0    | idle / waiting for byte 0 of a word
// B1    | byte 0 held, waiting for byte 1
// B2    | bytes 0..1 held, waiting for byte 2
// B3    | bytes 0..2 held, next accepted byte completes the word
module conv_8bto32b #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   conv_8bto32b_if.slave  bus
);

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2,
      B3 = 2'd3
   } state_t;

   state_t      r_state;
   logic [23:0] r_hold;
   logic [31:0] r_data_out;
   logic        r_valid_out;
   logic        r_err_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= B0;
         r_hold      <= 24'h0;
         r_data_out  <= 32'h0;
         r_valid_out <= 1'b0;
         r_err_out   <= 1'b0;
      end else begin
         r_valid_out <= 1'b0;
         r_err_out   <= 1'b0;
         if (bus.valid_in) begin
            // sop mid-word drops the partial word and restarts with this byte as byte 0
            if (bus.sop_in && (r_state != B0)) begin
               r_hold    <= {bus.data_in, 16'h0};
               r_state   <= B1;
               r_err_out <= 1'b1;
            end else begin
               unique case (r_state)
                  B0: begin
                     r_hold[23:16] <= bus.data_in;
                     r_state       <= B1;
                  end
                  B1: begin
                     r_hold[15:8] <= bus.data_in;
                     r_state      <= B2;
                  end
                  B2: begin
                     r_hold[7:0] <= bus.data_in;
                     r_state     <= B3;
                  end
                  B3: begin
                     if (MSB_FIRST)
                        r_data_out <= {r_hold, bus.data_in};
                     else
                        r_data_out <= {bus.data_in, r_hold[7:0], r_hold[15:8], r_hold[23:16]};
                     r_valid_out <= 1'b1;
                     r_state     <= B0;
                  end
               endcase
            end
         end
      end
   end

   assign bus.data_out  = r_data_out;
   assign bus.valid_out = r_valid_out;
   assign bus.err_out   = r_err_out;

endmodule

// File: tb/tb_conv_8bto32b.sv
// Bench for conv_8bto32b: both byte orders driven in lockstep and checked against a queue-based word model.
module tb_conv_8bto32b;

   logic clk;
   logic reset;

   conv_8bto32b_if if_m ();
   conv_8bto32b_if if_l ();

   conv_8bto32b #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(if_m.slave));
   conv_8bto32b #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(if_l.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   logic [7:0]  part[$];
   logic [31:0] exp_msb;
   logic [31:0] exp_lsb;
   logic        exp_valid;
   logic        exp_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string where);
      chk({where, "_msb_data"},  if_m.data_out,        exp_msb);
      chk({where, "_msb_valid"}, {31'h0, if_m.valid_out}, {31'h0, exp_valid});
      chk({where, "_msb_err"},   {31'h0, if_m.err_out},   {31'h0, exp_err});
      chk({where, "_lsb_data"},  if_l.data_out,        exp_lsb);
      chk({where, "_lsb_valid"}, {31'h0, if_l.valid_out}, {31'h0, exp_valid});
      chk({where, "_lsb_err"},   {31'h0, if_l.err_out},   {31'h0, exp_err});
   endtask

   task automatic model_reset();
      part.delete();
      exp_msb   = 32'h0;
      exp_lsb   = 32'h0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
   endtask

   // One clock cycle: present a byte (or idle), advance the model, check both DUTs.
   task automatic step(input logic [7:0] d, input logic v, input logic s);
      if_m.data_in = d; if_m.valid_in = v; if_m.sop_in = s;
      if_l.data_in = d; if_l.valid_in = v; if_l.sop_in = s;
      @(posedge clk);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (v) begin
         if (s && part.size() != 0) begin
            part.delete();
            exp_err = 1'b1;
         end
         part.push_back(d);
         if (part.size() == 4) begin
            exp_msb = (32'(part[0]) << 24) + (32'(part[1]) << 16) + (32'(part[2]) << 8) + 32'(part[3]);
            exp_lsb = (32'(part[3]) << 24) + (32'(part[2]) << 16) + (32'(part[1]) << 8) + 32'(part[0]);
            exp_valid = 1'b1;
            part.delete();
         end
      end
      #1;
      chk_all("step");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
   endtask

   // Reset pulse strictly between clock edges so only the asynchronous path can clear state.
   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk_all("async_rst");
      #2 reset = 1'b0;
   endtask

   int vcount;

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      reset = 1'b1;
      if_m.data_in = 8'h00; if_m.valid_in = 1'b0; if_m.sop_in = 1'b0;
      if_l.data_in = 8'h00; if_l.valid_in = 1'b0; if_l.sop_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("por");
      #3 reset = 1'b0;
      idle(3);

      // continuous stream with sop on 11 and 55
      vcount = 0;
      step(8'h11, 1'b1, 1'b1);
      step(8'h22, 1'b1, 1'b0);
      step(8'h33, 1'b1, 1'b0);
      step(8'h44, 1'b1, 1'b0);
      chk("word1_msb", if_m.data_out, 32'h11223344);
      chk("word1_lsb", if_l.data_out, 32'h44332211);
      vcount += int'(if_m.valid_out);
      step(8'h55, 1'b1, 1'b1); vcount += int'(if_m.valid_out);
      step(8'h66, 1'b1, 1'b0); vcount += int'(if_m.valid_out);
      step(8'h77, 1'b1, 1'b0); vcount += int'(if_m.valid_out);
      step(8'h88, 1'b1, 1'b0); vcount += int'(if_m.valid_out);
      chk("word2_msb", if_m.data_out, 32'h55667788);
      step(8'h00, 1'b0, 1'b0); vcount += int'(if_m.valid_out);
      chk("stream_pulses", 32'(vcount), 32'd2);

      // gapped stream, sop on an idle cycle must be ignored
      step(8'hAA, 1'b1, 1'b0);
      idle(3);
      step(8'hBB, 1'b1, 1'b0);
      step(8'hCC, 1'b1, 1'b0);
      step(8'h5A, 1'b0, 1'b1);
      step(8'hDD, 1'b1, 1'b0);
      chk("gap_word", if_m.data_out, 32'hAABBCCDD);
      idle(3);
      chk("gap_hold", if_m.data_out, 32'hAABBCCDD);

      // resync after a partial word
      step(8'h01, 1'b1, 1'b0);
      step(8'h02, 1'b1, 1'b0);
      step(8'h10, 1'b1, 1'b1);
      chk("resync_err", {31'h0, if_m.err_out}, 32'h1);
      step(8'h20, 1'b1, 1'b0);
      step(8'h30, 1'b1, 1'b0);
      step(8'h40, 1'b1, 1'b0);
      chk("resync_word", if_m.data_out, 32'h10203040);
      idle(1);

      // reset mid-word
      step(8'h01, 1'b1, 1'b0);
      step(8'h02, 1'b1, 1'b0);
      step(8'h03, 1'b1, 1'b0);
      pulse_reset();
      idle(2);
      step(8'h0A, 1'b1, 1'b0);
      step(8'h0B, 1'b1, 1'b0);
      step(8'h0C, 1'b1, 1'b0);
      step(8'h0D, 1'b1, 1'b0);
      chk("post_rst_word", if_m.data_out, 32'h0A0B0C0D);
      chk("post_rst_lsb",  if_l.data_out, 32'h0D0C0B0A);

      // randomized traffic with occasional sop and resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) pulse_reset();
         step(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0);
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv_8bto32b.md
# conv_8bto32b

Byte-to-word deserializer: collects four consecutive 8-bit bytes from a byte stream and presents them as one 32-bit word with a single-cycle valid pulse. It is the receive-side counterpart of the 32-bit-to-8-bit serializer. It sits at the byte-link boundary, restoring the original words. RTL is synthesized against the team's CMOS cell set (NOT/NAND/NOR/DFF/DFFSR), so every flop maps to DFFSR with R driven by reset.

## Interface
- MSB_FIRST, default 1: 1 = first byte of a word lands in data_out[31:24]; 0 = first byte lands in data_out[7:0].
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_in  in  8  byte from the link, sampled when valid_in=1.
- valid_in  in  1  data_in carries a valid byte this cycle.
- sop_in  in  1  start-of-word marker, qualified by valid_in; the byte is byte 0 of a word.
- data_out  out  32  last completed word; held until the next word completes.
- valid_out  out  1  one-cycle pulse: data_out was updated on this edge.
- err_out  out  1  one-cycle pulse: a partial word was discarded due to sop_in mid-word.

## Operation
- Internal state:
  - byte counter cnt, 2 bits, values 0..3;
  - 24-bit shift/hold register for bytes 0..2;
  - output registers data_out, valid_out, err_out.
- Reset values: cnt=0, hold=0, data_out=32'h0000_0000, valid_out=0, err_out=0.
- States are encoded by cnt:
  - IDLE/B0 (cnt=0) -> B1 -> B2 -> B3 -> B0.
  - A transition happens only on a cycle with valid_in=1.
- valid_in=0: cnt, hold and data_out keep their values. valid_out=0, err_out=0 on the next edge. Gaps of any length are allowed between bytes.
- valid_in=1, sop_in=0:
  - cnt<3: store the byte at position cnt, then cnt=cnt+1.
  - cnt==3: data_out = {byte0,byte1,byte2,data_in}, reordered per MSB_FIRST. Then valid_out=1 and cnt wraps to 0.
- valid_in=1, sop_in=1:
  - cnt==0: treated as a normal byte 0.
  - cnt!=0: discard the partial word, store data_in as byte 0, set cnt=1, pulse err_out=1.
  - data_out is not modified and valid_out stays 0.
- sop_in with valid_in=0 is ignored.
- With MSB_FIRST=0, the word is {data_in,byte2,byte1,byte0}.
- A word may start without sop_in. Alignment after reset is the first valid byte.

## Timing
- Latency: valid_out rises on the same clk edge that samples the 4th byte. It is visible in the cycle after that byte was presented, and is high for exactly one cycle.
- Throughput: one byte per cycle. With continuous valid_in, valid_out pulses every 4th cycle. The byte following the 4th is accepted as byte 0 on the next edge, with no bubble.
- err_out asserts on the edge that samples the offending sop_in byte. It is high for one cycle and is never simultaneous with valid_out.
- Mid-operation reset: outputs and cnt go to reset values asynchronously, without waiting for clk. The first valid byte after reset deasserts is byte 0.
- data_out changes only on edges where valid_out goes to 1.

## Test plan
- Reset check: assert reset mid-cycle with no clock edge -> data_out=0, valid_out=0 and err_out=0 immediately. After release, idle inputs -> outputs stay 0.
- Continuous stream, MSB_FIRST=1: bytes 11,22,33,44,55,66,77,88 on consecutive cycles, sop on 11 and 55:
  - 32'h11223344 appears with valid_out one cycle after byte 44;
  - 32'h55667788 appears 4 cycles later;
  - valid_out is high exactly 2 cycles in total.
- Gapped stream: bytes AA,(idle 3 cycles),BB,CC,(idle),DD -> a single valid_out pulse with 32'hAABBCCDD. data_out holds its value through later idle cycles.
- Resync: bytes 01,02 then sop with 10,20,30,40 ->
  - err_out pulses one cycle after byte 10;
  - no valid_out for 01/02;
  - next word is 32'h10203040.
- MSB_FIRST=0: bytes 11,22,33,44 -> data_out=32'h44332211.
- Reset mid-word: bytes 01,02,03, then pulse reset, then 0A,0B,0C,0D -> no word is output for 01..03; after the reset pulse, the next word is 32'h0A0B0C0D.
